// File: rtl/m_mem_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : m_mem_unit_if
//  Description : System-bridge request/acknowledge bus between the M-stage
//                load/store unit (master) and the DM / timer slaves.
//                  bus_req   master->slave  transaction request, held to ack
//                  bus_we    master->slave  1 = write
//                  bus_addr  master->slave  word-aligned byte address
//                  bus_be    master->slave  byte-lane enables
//                  bus_wdata master->slave  store data, lane-replicated
//                  bus_ack   slave->master  completion, rdata valid same cycle
//                  bus_rdata slave->master  read word
//  Revision    : 1.0  initial release
// ============================================================================
interface m_mem_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/m_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : m_mem_unit
//  Description : M-stage load/store unit. Checks the effective address for
//                legality, runs one req/ack transaction on the system bridge
//                (DM, timer0, timer1), returns the aligned and extended load
//                word and stalls the pipe until the access is finished.
//  Ports       :
//    clk        in   rising-edge clock
//    reset      in   asynchronous reset, active low
//    mem_valid  in   M-stage slot holds a live instruction
//    mem_op     in   0 none,1 LW,2 LH,3 LHU,4 LB,5 LBU,6 SW,7 SH,8 SB
//    addr       in   effective byte address from the ALU
//    addr_ovf   in   address-add overflow
//    wdata      in   store data
//    flush      in   CP0 kill of the M-stage instruction
//    bus        --   bridge master port (m_mem_unit_if.master)
//    stall_m    out  hold F..M stages
//    ld_data    out  extended load result (valid with ld_valid)
//    ld_valid   out  one-cycle load-complete pulse
//    exc_adel   out  load address error
//    exc_ades   out  store address error
//    exc_bus    out  one-cycle bus-timeout pulse
//  Revision    : 1.0  initial release
// ============================================================================
module m_mem_unit #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] DM_END   = 32'h0000_2FFF,
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_valid,
    input  logic [3:0]   mem_op,
    input  logic [31:0]  addr,
    input  logic         addr_ovf,
    input  logic [31:0]  wdata,
    input  logic         flush,
    m_mem_unit_if.master bus,
    output logic         stall_m,
    output logic [31:0]  ld_data,
    output logic         ld_valid,
    output logic         exc_adel,
    output logic         exc_ades,
    output logic         exc_bus
);

    localparam logic [3:0] c_op_lw  = 4'd1;
    localparam logic [3:0] c_op_lh  = 4'd2;
    localparam logic [3:0] c_op_lhu = 4'd3;
    localparam logic [3:0] c_op_lb  = 4'd4;
    localparam logic [3:0] c_op_lbu = 4'd5;
    localparam logic [3:0] c_op_sw  = 4'd6;
    localparam logic [3:0] c_op_sh  = 4'd7;
    localparam logic [3:0] c_op_sb  = 4'd8;

    // Timer counts 0..TIMEOUT-1 while in BUSY.
    localparam int                c_tw         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_tw-1:0]   c_timer_last = c_tw'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_tw-1:0] r_timer;
    logic [c_tw-1:0] w_timer_nxt;
    logic            r_killed;
    logic            w_killed_nxt;
    logic            r_req;
    logic            w_req_nxt;
    logic            r_exc_bus;
    logic            w_exc_bus_nxt;
    logic            w_ld_latch;
    logic            w_stall;

    // Latched transaction
    logic [3:0]      r_op;
    logic [1:0]      r_lane;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [3:0]      r_be;
    logic [31:0]     r_wdata;
    logic [31:0]     r_ld_data;

    // ------------------------------------------------------------------
    // Op decode and address legality
    // ------------------------------------------------------------------
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_word;
    logic        w_is_half;
    logic        w_op_live;
    logic        w_in_dm;
    logic        w_in_tc0;
    logic        w_in_tc1;
    logic [31:0] w_tc0_off;
    logic [31:0] w_tc1_off;
    logic        w_tc_count;
    logic        w_misalign;
    logic        w_addr_err;
    logic        w_can_act;
    logic        w_issue;

    assign w_is_load  = (mem_op >= c_op_lw) && (mem_op <= c_op_lbu);
    assign w_is_store = (mem_op >= c_op_sw) && (mem_op <= c_op_sb);
    assign w_is_word  = (mem_op == c_op_lw) || (mem_op == c_op_sw);
    assign w_is_half  = (mem_op == c_op_lh) || (mem_op == c_op_lhu) || (mem_op == c_op_sh);
    assign w_op_live  = mem_valid && (w_is_load || w_is_store) && !flush;

    assign w_tc0_off  = addr - TC0_BASE;
    assign w_tc1_off  = addr - TC1_BASE;
    assign w_in_dm    = (addr <= DM_END);
    assign w_in_tc0   = (addr >= TC0_BASE) && (w_tc0_off <= 32'd11);
    assign w_in_tc1   = (addr >= TC1_BASE) && (w_tc1_off <= 32'd11);
    // Word 2 of each timer is the free-running count: read-only.
    assign w_tc_count = (w_in_tc0 && (w_tc0_off[3:2] == 2'd2)) ||
                        (w_in_tc1 && (w_tc1_off[3:2] == 2'd2));
    assign w_misalign = (w_is_word && (addr[1:0] != 2'b00)) || (w_is_half && addr[0]);

    assign w_addr_err = addr_ovf || w_misalign ||
                        !(w_in_dm || w_in_tc0 || w_in_tc1) ||
                        ((w_in_tc0 || w_in_tc1) && !w_is_word) ||
                        (w_is_store && w_tc_count);

    // The IDLE cycle that carries a bus-timeout pulse hands the instruction
    // to CP0 instead of re-issuing it. Reset gates the combinational
    // outputs so everything reads 0 while reset is low.
    assign w_can_act = reset && (r_state == ST_IDLE) && w_op_live && !r_exc_bus;
    assign w_issue   = w_can_act && !w_addr_err;
    assign exc_adel  = w_can_act && w_addr_err && w_is_load;
    assign exc_ades  = w_can_act && w_addr_err && w_is_store;

    // ------------------------------------------------------------------
    // Byte lanes and store-data replication for the op being issued
    // ------------------------------------------------------------------
    logic [3:0]  w_be_nxt;
    logic [31:0] w_wd_nxt;

    always_comb begin
        w_be_nxt = 4'b1111;
        w_wd_nxt = 32'h0000_0000;
        case (mem_op)
            c_op_sw: begin
                w_be_nxt = 4'b1111;
                w_wd_nxt = wdata;
            end
            c_op_sh: begin
                w_be_nxt = 4'b0011 << addr[1:0];
                w_wd_nxt = {2{wdata[15:0]}};
            end
            c_op_sb: begin
                w_be_nxt = 4'b0001 << addr[1:0];
                w_wd_nxt = {4{wdata[7:0]}};
            end
            default: begin
                w_be_nxt = 4'b1111;
                w_wd_nxt = 32'h0000_0000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------
    logic [31:0] w_rd_shift;
    logic [31:0] w_ld_ext;

    assign w_rd_shift = bus.bus_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_ld_ext = bus.bus_rdata;
        case (r_op)
            c_op_lb:  w_ld_ext = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            c_op_lbu: w_ld_ext = {24'h000000, w_rd_shift[7:0]};
            c_op_lh:  w_ld_ext = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            c_op_lhu: w_ld_ext = {16'h0000, w_rd_shift[15:0]};
            default:  w_ld_ext = bus.bus_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_killed_nxt  = r_killed;
        w_req_nxt     = r_req;
        w_exc_bus_nxt = 1'b0;
        w_ld_latch    = 1'b0;
        w_stall       = 1'b0;
        ld_valid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_issue;
                if (w_issue) begin
                    w_state_nxt  = ST_BUSY;
                    w_req_nxt    = 1'b1;
                    w_timer_nxt  = '0;
                    w_killed_nxt = 1'b0;
                end
            end
            ST_BUSY: begin
                // Once killed the pipe moves on; only a younger op waiting
                // behind the drain is held.
                w_stall     = r_killed ? w_op_live : !flush;
                w_timer_nxt = r_timer + 1'b1;
                if (flush) begin
                    w_killed_nxt = 1'b1;
                end
                if (bus.bus_ack) begin
                    w_state_nxt = ST_DONE;
                    w_req_nxt   = 1'b0;
                    w_ld_latch  = !r_we;
                end else if (r_timer == c_timer_last) begin
                    w_state_nxt   = ST_IDLE;
                    w_req_nxt     = 1'b0;
                    w_killed_nxt  = 1'b0;
                    // A killed access has no one left to take the exception.
                    w_exc_bus_nxt = !(r_killed || flush);
                end
            end
            ST_DONE: begin
                w_stall      = r_killed ? w_op_live : 1'b0;
                ld_valid     = !r_we && !r_killed && !flush;
                w_state_nxt  = ST_IDLE;
                w_killed_nxt = 1'b0;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_req_nxt    = 1'b0;
                w_killed_nxt = 1'b0;
            end
        endcase
    end

    assign stall_m = reset && w_stall;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_killed  <= 1'b0;
            r_req     <= 1'b0;
            r_exc_bus <= 1'b0;
            r_op      <= 4'd0;
            r_lane    <= 2'b00;
            r_we      <= 1'b0;
            r_addr    <= 32'h0000_0000;
            r_be      <= 4'b0000;
            r_wdata   <= 32'h0000_0000;
            r_ld_data <= 32'h0000_0000;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_killed  <= w_killed_nxt;
            r_req     <= w_req_nxt;
            r_exc_bus <= w_exc_bus_nxt;
            if (w_issue) begin
                r_op    <= mem_op;
                r_lane  <= addr[1:0];
                r_we    <= w_is_store;
                r_addr  <= {addr[31:2], 2'b00};
                r_be    <= w_be_nxt;
                r_wdata <= w_wd_nxt;
            end
            if (w_ld_latch) begin
                r_ld_data <= w_ld_ext;
            end
        end
    end

    assign bus.bus_req   = r_req;
    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_be    = r_be;
    assign bus.bus_wdata = r_wdata;
    assign ld_data       = r_ld_data;
    assign exc_bus       = r_exc_bus;

endmodule
`default_nettype wire

// File: tb/tb_m_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_mem_unit
//  Description : Self-checking bench for m_mem_unit. A vector table covers
//                legal accesses and address errors; hand-written sequences
//                cover bus timeout, flush drain and asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_m_mem_unit;

    localparam logic [3:0] LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4, LBU = 4'd5;
    localparam logic [3:0] SW = 4'd6, SH = 4'd7, SB = 4'd8;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic        addr_ovf;
    logic [31:0] wdata;
    logic        flush;
    logic        stall_m;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_bus;

    m_mem_unit_if bus_if ();

    m_mem_unit dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_op    (mem_op),
        .addr      (addr),
        .addr_ovf  (addr_ovf),
        .wdata     (wdata),
        .flush     (flush),
        .bus       (bus_if),
        .stall_m   (stall_m),
        .ld_data   (ld_data),
        .ld_valid  (ld_valid),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .exc_bus   (exc_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ovf;
        logic [31:0] rdata;
        int          ack_dly;   // request cycles before ack
        int          exc;       // 0 none, 1 AdEL, 2 AdES
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] ld;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    vec_t        vecs[$];
    bus_t        q_bus[$];
    logic [31:0] q_ld[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                                input logic ovf, input logic [31:0] rd, input int dly, input int exc,
                                input logic [3:0] be, input logic [31:0] bwd, input logic [31:0] ld);
        vec_t v;
        v.op = op; v.addr = a; v.wdata = wd; v.ovf = ovf; v.rdata = rd;
        v.ack_dly = dly; v.exc = exc; v.be = be; v.bwdata = bwd; v.ld = ld;
        return v;
    endfunction

    // Drive one op from the table at posedge+1 and follow it to completion.
    task automatic run_vec(input vec_t v);
        bus_t eb;
        bus_t gb;
        logic is_ld;
        int   n;
        int   req_n;
        int   stalls;
        bit   done;
        bit   seen;
        is_ld = (v.op >= LW) && (v.op <= LBU);
        mem_valid = 1'b1; mem_op = v.op; addr = v.addr; addr_ovf = v.ovf; wdata = v.wdata;
        if (v.exc == 0) begin
            eb.we = !is_ld; eb.addr = v.addr & 32'hFFFF_FFFC; eb.be = v.be; eb.wd = v.bwdata;
            q_bus.push_back(eb);
            if (is_ld) q_ld.push_back(v.ld);
        end
        @(negedge clk);
        chk("exc_adel", 32'(exc_adel), 32'(v.exc == 1));
        chk("exc_ades", 32'(exc_ades), 32'(v.exc == 2));
        if (v.exc != 0) begin
            chk("stall_on_exc", 32'(stall_m), 32'd0);
            @(posedge clk); #1;
            mem_valid = 1'b0;
            chk("no_req_on_exc", 32'(bus_if.bus_req), 32'd0);
        end else begin
            stalls = stall_m ? 1 : 0;
            req_n = 0; seen = 1'b0; done = 1'b0; n = 0;
            @(posedge clk); #1;
            while (!done && n < 40) begin
                if (bus_if.bus_req) begin
                    if (!seen) begin
                        seen = 1'b1;
                        if (q_bus.size() > 0) begin
                            gb = q_bus.pop_front();
                            chk("bus_we", 32'(bus_if.bus_we), 32'(gb.we));
                            chk("bus_addr", bus_if.bus_addr, gb.addr);
                            chk("bus_be", 32'(bus_if.bus_be), 32'(gb.be));
                            if (gb.we) chk("bus_wdata", bus_if.bus_wdata, gb.wd);
                        end else begin
                            chk("bus_unexpected", 32'(bus_if.bus_req), 32'd0);
                        end
                    end
                    bus_if.bus_ack   = (req_n == v.ack_dly);
                    bus_if.bus_rdata = v.rdata;
                    req_n++;
                end
                @(negedge clk);
                if (stall_m) begin
                    stalls++;
                end else begin
                    done = 1'b1;
                    chk("ld_valid", 32'(ld_valid), 32'(is_ld));
                    if (is_ld && q_ld.size() > 0) chk("ld_data", ld_data, q_ld.pop_front());
                    chk("exc_bus_idle", 32'(exc_bus), 32'd0);
                end
                @(posedge clk); #1;
                bus_if.bus_ack = 1'b0;
                n++;
            end
            mem_valid = 1'b0;
            chk("completed", 32'(done), 32'd1);
            chk("stall_cycles", 32'(stalls), 32'(v.ack_dly + 2));
            chk("req_cycles", 32'(req_n), 32'(v.ack_dly + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int n_ld;
        reset = 1'b0; mem_valid = 1'b1; mem_op = LW; addr = 32'h1004;
        addr_ovf = 1'b0; wdata = 32'h0; flush = 1'b0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;

        // Legal op presented while reset is held: every output stays 0.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst_stall", 32'(stall_m), 32'd0);
        chk("rst_outs", 32'({ld_valid, exc_adel, exc_ades, exc_bus}), 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
        mem_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        //               op   addr           wdata          ovf  rdata          dly exc be       bwdata         ld
        vecs.push_back(mk(LW,  32'h0000_1004, 32'h0,         0, 32'h89AB_CDEF, 0, 0, 4'b1111, 32'h0,         32'h89AB_CDEF));
        vecs.push_back(mk(LB,  32'h0000_0003, 32'h0,         0, 32'h8011_2233, 0, 0, 4'b1111, 32'h0,         32'hFFFF_FF80));
        vecs.push_back(mk(LBU, 32'h0000_0003, 32'h0,         0, 32'h8011_2233, 1, 0, 4'b1111, 32'h0,         32'h0000_0080));
        vecs.push_back(mk(SH,  32'h0000_0002, 32'h0000_1234, 0, 32'h0,         0, 0, 4'b1100, 32'h1234_1234, 32'h0));
        vecs.push_back(mk(LH,  32'h0000_0002, 32'h0,         0, 32'h8001_5555, 2, 0, 4'b1111, 32'h0,         32'hFFFF_8001));
        vecs.push_back(mk(LHU, 32'h0000_0002, 32'h0,         0, 32'h8001_5555, 1, 0, 4'b1111, 32'h0,         32'h0000_8001));
        vecs.push_back(mk(SB,  32'h0000_0101, 32'h0000_00AB, 0, 32'h0,         0, 0, 4'b0010, 32'hABAB_ABAB, 32'h0));
        vecs.push_back(mk(SW,  32'h0000_7F04, 32'hDEAD_BEEF, 0, 32'h0,         3, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0));
        vecs.push_back(mk(LW,  32'h0000_7F18, 32'h0,         0, 32'h1234_5678, 0, 0, 4'b1111, 32'h0,         32'h1234_5678));
        vecs.push_back(mk(LW,  32'h0000_2FFC, 32'h0,         0, 32'hCAFE_F00D, 0, 0, 4'b1111, 32'h0,         32'hCAFE_F00D));
        vecs.push_back(mk(LB,  32'h0000_0000, 32'h0,         0, 32'h0000_007F, 0, 0, 4'b1111, 32'h0,         32'h0000_007F));
        vecs.push_back(mk(LW,  32'h0000_0008, 32'h0,         0, 32'h1111_1111, 15, 0, 4'b1111, 32'h0,        32'h1111_1111));
        vecs.push_back(mk(LW,  32'h0000_0002, 32'h0,         0, 32'h0,         0, 1, 4'b0000, 32'h0,         32'h0));
        vecs.push_back(mk(SW,  32'h0000_7F08, 32'h1,         0, 32'h0,         0, 2, 4'b0000, 32'h0,         32'h0));
        vecs.push_back(mk(SH,  32'h0000_7F00, 32'h1,         0, 32'h0,         0, 2, 4'b0000, 32'h0,         32'h0));
        vecs.push_back(mk(LW,  32'h0000_4000, 32'h0,         0, 32'h0,         0, 1, 4'b0000, 32'h0,         32'h0));
        vecs.push_back(mk(SB,  32'h0000_0000, 32'h5,         1, 32'h0,         0, 2, 4'b0000, 32'h0,         32'h0));
        vecs.push_back(mk(LW,  32'h0000_3000, 32'h0,         0, 32'h0,         0, 1, 4'b0000, 32'h0,         32'h0));
        vecs.push_back(mk(LW,  32'h0000_7F0C, 32'h0,         0, 32'h0,         0, 1, 4'b0000, 32'h0,         32'h0));
        vecs.push_back(mk(LB,  32'h0000_7F10, 32'h0,         0, 32'h0,         0, 1, 4'b0000, 32'h0,         32'h0));

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // ---- Bus timeout: no ack ever ----
        mem_valid = 1'b1; mem_op = LW; addr = 32'h0000_0010; addr_ovf = 1'b0;
        @(posedge clk); #1;
        n = 0;
        while (bus_if.bus_req && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        chk("to_req_cycles", 32'(n), 32'd16);
        chk("to_exc_bus", 32'(exc_bus), 32'd1);
        @(negedge clk);
        chk("to_stall", 32'(stall_m), 32'd0);
        chk("to_no_reissue", 32'(bus_if.bus_req), 32'd0);
        @(posedge clk); #1;
        mem_valid = 1'b0;
        chk("to_exc_bus_pulse", 32'(exc_bus), 32'd0);

        // ---- Flush during BUSY, then a back-to-back SW waiting on the drain ----
        mem_valid = 1'b1; mem_op = LW; addr = 32'h0000_0100; wdata = 32'h0; flush = 1'b0;
        @(posedge clk); #1;
        chk("fl_req", 32'(bus_if.bus_req), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_stall_flush", 32'(stall_m), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; mem_op = SW; addr = 32'h0000_0200; wdata = 32'hA5A5_0F0F;
        n_ld = 0;
        for (int c = 2; c <= 6; c++) begin
            if (c == 4) chk("fl_req_held", 32'(bus_if.bus_req), 32'd1);
            bus_if.bus_ack   = (c == 4);
            bus_if.bus_rdata = 32'h1357_9BDF;
            @(negedge clk);
            chk("fl_hold", 32'(stall_m), 32'd1);
            if (ld_valid) n_ld++;
            @(posedge clk); #1;
            bus_if.bus_ack = 1'b0;
        end
        chk("fl_no_ld_valid", 32'(n_ld), 32'd0);
        chk("fl_sw_req", 32'(bus_if.bus_req), 32'd1);
        chk("fl_sw_we", 32'(bus_if.bus_we), 32'd1);
        chk("fl_sw_addr", bus_if.bus_addr, 32'h0000_0200);
        chk("fl_sw_be", 32'(bus_if.bus_be), 32'hF);
        chk("fl_sw_wdata", bus_if.bus_wdata, 32'hA5A5_0F0F);
        bus_if.bus_ack = 1'b1;
        @(negedge clk);
        chk("fl_sw_stall", 32'(stall_m), 32'd1);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        @(negedge clk);
        chk("fl_sw_done", 32'(stall_m), 32'd0);
        chk("fl_sw_no_ld", 32'(ld_valid), 32'd0);
        @(posedge clk); #1;
        mem_valid = 1'b0;

        // ---- Asynchronous reset in the middle of a transaction ----
        mem_valid = 1'b1; mem_op = LW; addr = 32'h0000_0004;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("ar_req_before", 32'(bus_if.bus_req), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ar_req", 32'(bus_if.bus_req), 32'd0);
        chk("ar_stall", 32'(stall_m), 32'd0);
        chk("ar_outs", 32'({ld_valid, exc_adel, exc_ades, exc_bus}), 32'd0);
        mem_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("ar_idle", 32'(bus_if.bus_req), 32'd0);
        run_vec(mk(LW, 32'h0000_0004, 32'h0, 0, 32'h0F0E_0D0C, 1, 0, 4'b1111, 32'h0, 32'h0F0E_0D0C));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
